fetch_queue: RTL

Parametrised prefetching instruction fetch unit for the bf8b core. It replaces the single-shot, pc-driven fetcher with one that owns the fetch PC and streams sequential reads into a DEPTH-entry instruction queue. The instruction memory has a fixed latency of MEM_LAT cycles. Decode consumes instructions through a valid/ready handshake. A redirect input supports `[`/`]` loop jumps by flushing queued and in-flight fetches and restarting at a new PC.

---
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Bundles the fetch unit's control inputs, memory bus and decode-side handshake.
// The fetch unit uses the master modport; memory and decode sit on the slave side.
interface fetch_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              en;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic [ADDR_W-1:0] fetch_pc;

  modport master (
    input  en, redirect, redirect_pc, mem_data, inst_ready,
    output mem_rd, mem_addr, inst_valid, inst_out, inst_pc, fetch_pc
  );

  modport slave (
    output en, redirect, redirect_pc, mem_data, inst_ready,
    input  mem_rd, mem_addr, inst_valid, inst_out, inst_pc, fetch_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: owns the fetch PC, streams sequential reads
// into a fixed-latency memory and buffers returns in a DEPTH-entry queue.
// Issue is throttled so queued + in-flight never exceeds DEPTH; redirect flushes both.
module fetch_queue #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2,
  parameter int DEPTH   = 4
) (
  input logic          clk,
  input logic          rst_n,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = $clog2(DEPTH + MEM_LAT + 1) + 1;

  logic [ADDR_W-1:0]  fetch_pc_q, mem_addr_q;
  logic               mem_rd_q;
  logic [MEM_LAT-1:0] tag_vld_q;
  logic [ADDR_W-1:0]  tag_pc_q [MEM_LAT];
  logic [DATA_W-1:0]  q_data_q [DEPTH];
  logic [ADDR_W-1:0]  q_pc_q   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  head_data_q, head_data_d;
  logic [ADDR_W-1:0]  head_pc_q, head_pc_d;
  logic [SUM_W-1:0]   inflight;
  logic               issue, push, pop;

  // Count outstanding requests and decide whether a new fetch may issue this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + SUM_W'(tag_vld_q[i]);
  end

  assign issue = bus.en && !bus.redirect &&
                 ((SUM_W'(count_q) + inflight) < SUM_W'(DEPTH));
  assign push  = tag_vld_q[MEM_LAT-1];
  assign pop   = (count_q != '0) && bus.inst_ready;

  // Fetch PC and registered memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc_q <= bus.redirect_pc;
      mem_rd_q   <= 1'b0;
    end else if (issue) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      mem_rd_q   <= 1'b1;
      mem_addr_q <= fetch_pc_q;
      fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
    end else begin
      mem_rd_q   <= 1'b0;
    end
  end

  // In-flight tag pipeline, aligned with the memory latency; redirect kills every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_pc_q[i] <= '0;
    end else if (bus.redirect) begin
      tag_vld_q <= '0;
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_pc_q[i]  <= tag_pc_q[i-1];
      end
      tag_vld_q[0] <= issue;
      tag_pc_q[0]  <= fetch_pc_q;
    end
  end

  // Queue bookkeeping and next head value; the head registers hold when the queue empties.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;
    if (bus.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (count_d != '0) begin
        if (push && (rd_ptr_d == wr_ptr_q)) begin
          head_data_d = bus.mem_data;
          head_pc_d   = tag_pc_q[MEM_LAT-1];
        end else begin
          head_data_d = q_data_q[rd_ptr_d];
          head_pc_d   = q_pc_q[rd_ptr_d];
        end
      end
    end
  end

  // Queue control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_data_q <= '0;
      head_pc_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
    end
  end

  // Queue storage written by returning fetches.
  // NOTE: storage is left unreset; count_q gates validity and the head registers carry the reset value.
  always_ff @(posedge clk) begin
    if (push && !bus.redirect) begin
      q_data_q[wr_ptr_q] <= bus.mem_data;
      q_pc_q[wr_ptr_q]   <= tag_pc_q[MEM_LAT-1];
    end
  end

  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.fetch_pc   = fetch_pc_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_out   = head_data_q;
  assign bus.inst_pc    = head_pc_q;

  // A return must always find room; the issue throttle guarantees it.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CNT_W'(DEPTH))));
endmodule
